axis_multichannel_boxcar_filter: RTL and testbench



---
 rtl/axis_multichannel_boxcar_filter_pkg.sv | 29 ++
 rtl/axis_multichannel_boxcar_filter_if.sv | 16 +
 rtl/axis_multichannel_boxcar_filter_history_ram.sv | 26 ++
 rtl/axis_multichannel_boxcar_filter.sv | 168 ++++++++++++++++
 tb/tb_axis_multichannel_boxcar_filter.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/axis_multichannel_boxcar_filter_pkg.sv
// Shared definitions for the multichannel boxcar filter.
//   - FSM state encoding (FLUSH, IDLE, READ, CALC, OUT)
//   - width helpers for the running sums, RAM address and channel index
package boxcar_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_FLUSH = 3'd0;
    localparam state_t ST_IDLE  = 3'd1;
    localparam state_t ST_READ  = 3'd2;
    localparam state_t ST_CALC  = 3'd3;
    localparam state_t ST_OUT   = 3'd4;

    // Running sum holds up to 2^max_log2 samples of aw bits without overflow.
    function automatic int sum_width(int aw, int max_log2);
        return aw + max_log2;
    endfunction

    // History RAM address: {channel, per-channel pointer}.
    function automatic int addr_width(int channels, int max_log2);
        return $clog2(channels) + max_log2;
    endfunction

    // Channel index register width; a single-channel build still needs one bit.
    function automatic int ch_width(int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/axis_multichannel_boxcar_filter_if.sv
// AXI-Stream style handshake bundle used on both sides of the filter.
//   data  : sample word
//   valid : source has a beat
//   ready : sink accepts the beat
//   last  : final channel of a frame
interface axis_multichannel_boxcar_filter_if #(
    parameter int TDATA_WIDTH = 32
);
    logic [TDATA_WIDTH-1:0] data;
    logic                   valid;
    logic                   ready;
    logic                   last;

    modport master (output data, output valid, output last, input  ready);
    modport slave  (input  data, input  valid, input  last, output ready);
endinterface

// File: rtl/axis_multichannel_boxcar_filter_history_ram.sv
// Simple dual-port history RAM, synchronous read.
//   clk   : clock
//   we    : write enable
//   waddr : write address, wdata : write data
//   raddr : read address,  rdata : registered read data (one cycle later)
// A read and a write to the same address in one cycle return the old contents.
module boxcar_history_ram #(
    parameter int DEPTH  = 512,
    parameter int WIDTH  = 24,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/axis_multichannel_boxcar_filter.sv
// Per-channel moving-average (boxcar) filter on an interleaved AXIS audio stream.
//   clk, reset    : clock, synchronous active-high reset
//   filter_enable : 1 = averaged output, 0 = raw sample (history still updated)
//   window_log2   : requested log2 window, clamped to MAX_LOG2_WIN
//   s_axis        : input stream (slave), m_axis : output stream (master)
//   frame_err     : sticky, last flag seen on a channel other than CHANNELS-1
//   busy_flush    : history RAM and sums are being cleared
// One sample is in flight at a time: IDLE -> READ -> CALC -> OUT.
module axis_multichannel_boxcar_filter
    import boxcar_pkg::*;
#(
    parameter int TDATA_WIDTH  = 32,
    parameter int AUDIO_WIDTH  = 24,
    parameter int CHANNELS     = 2,
    parameter int MAX_LOG2_WIN = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              filter_enable,
    input  logic [3:0]                        window_log2,
    axis_multichannel_boxcar_filter_if.slave  s_axis,
    axis_multichannel_boxcar_filter_if.master m_axis,
    output logic                              frame_err,
    output logic                              busy_flush
);
    localparam int SUM_W     = sum_width(AUDIO_WIDTH, MAX_LOG2_WIN);
    localparam int ADDR_W    = addr_width(CHANNELS, MAX_LOG2_WIN);
    localparam int CH_W      = ch_width(CHANNELS);
    localparam int PTR_W     = MAX_LOG2_WIN;
    localparam int WIN_W     = MAX_LOG2_WIN + 1;
    localparam int RAM_DEPTH = CHANNELS << MAX_LOG2_WIN;

    state_t                             state;
    logic [ADDR_W-1:0]                  flush_addr;
    logic [3:0]                         k_q, k_req;
    logic [CHANNELS-1:0][SUM_W-1:0]     sum_q;
    logic [CHANNELS-1:0][PTR_W-1:0]     wptr_q;
    logic [CH_W-1:0]                    ch_idx, cur_ch;
    logic [TDATA_WIDTH-1:0]             in_data, m_data;
    logic                               in_last, in_en, m_valid, m_last;

    logic                               ram_we;
    logic [ADDR_W-1:0]                  ram_waddr, ram_raddr;
    logic [AUDIO_WIDTH-1:0]             ram_wdata, ram_rdata;

    logic [PTR_W-1:0]                   cur_wptr, rd_ptr;
    logic [WIN_W-1:0]                   win_len;
    logic signed [SUM_W-1:0]            new_ext, old_ext, sum_next, rnd, rounded;
    logic [AUDIO_WIDTH-1:0]             filtered;

    // Channel in the upper address bits; drops out when CHANNELS == 1.
    function automatic logic [ADDR_W-1:0] mk_addr(input logic [CH_W-1:0] c,
                                                  input logic [PTR_W-1:0] p);
        logic [CH_W+PTR_W-1:0] t;
        t = {c, p};
        return t[ADDR_W-1:0];
    endfunction

    assign k_req = (window_log2 > 4'(MAX_LOG2_WIN)) ? 4'(MAX_LOG2_WIN) : window_log2;

    // Ready is withheld while a window change is pending so that no beat
    // is accepted in the same cycle the FSM decides to flush.
    assign s_axis.ready  = (state == ST_IDLE) && (k_req == k_q);
    assign busy_flush    = (state == ST_FLUSH);
    assign m_axis.data   = m_data;
    assign m_axis.valid  = m_valid;
    assign m_axis.last   = m_last;

    // Oldest sample sits 2^k slots behind the write pointer. Subtracting in
    // WIN_W bits and truncating makes k == MAX land on the write slot itself.
    always_comb begin
        cur_wptr  = wptr_q[cur_ch];
        win_len   = WIN_W'(1) << k_q;
        rd_ptr    = PTR_W'({1'b0, cur_wptr} - win_len);
        ram_raddr = mk_addr(cur_ch, rd_ptr);
        ram_we    = (state == ST_FLUSH) || (state == ST_CALC);
        ram_waddr = (state == ST_FLUSH) ? flush_addr : mk_addr(cur_ch, cur_wptr);
        ram_wdata = (state == ST_FLUSH) ? '0 : in_data[AUDIO_WIDTH-1:0];
    end

    // Sum update and round-half-up average; k == 0 degenerates to identity.
    always_comb begin
        new_ext  = {{MAX_LOG2_WIN{in_data[AUDIO_WIDTH-1]}}, in_data[AUDIO_WIDTH-1:0]};
        old_ext  = {{MAX_LOG2_WIN{ram_rdata[AUDIO_WIDTH-1]}}, ram_rdata};
        sum_next = $signed(sum_q[cur_ch]) + new_ext - old_ext;
        rnd      = (k_q == 4'd0) ? '0 : (SUM_W'(1) << (k_q - 4'd1));
        rounded  = (sum_next + rnd) >>> k_q;
        filtered = AUDIO_WIDTH'(rounded);
    end

    boxcar_history_ram #(
        .DEPTH  (RAM_DEPTH),
        .WIDTH  (AUDIO_WIDTH),
        .ADDR_W (ADDR_W)
    ) u_hist (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_FLUSH;
            flush_addr <= '0;
            k_q        <= k_req;
            sum_q      <= '0;
            wptr_q     <= '0;
            ch_idx     <= '0;
            cur_ch     <= '0;
            in_data    <= '0;
            in_last    <= 1'b0;
            in_en      <= 1'b0;
            m_data     <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            case (state)
                ST_FLUSH: begin
                    // flush_addr wraps back to 0 on the final write.
                    flush_addr <= flush_addr + 1'b1;
                    if (flush_addr == ADDR_W'(RAM_DEPTH - 1))
                        state <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (k_req != k_q) begin
                        k_q    <= k_req;
                        sum_q  <= '0;
                        wptr_q <= '0;
                        state  <= ST_FLUSH;
                    end else if (s_axis.valid) begin
                        in_data <= s_axis.data;
                        in_last <= s_axis.last;
                        in_en   <= filter_enable;
                        cur_ch  <= ch_idx;
                        if (s_axis.last && ch_idx != CH_W'(CHANNELS - 1))
                            frame_err <= 1'b1;
                        if (s_axis.last || ch_idx == CH_W'(CHANNELS - 1))
                            ch_idx <= '0;
                        else
                            ch_idx <= ch_idx + 1'b1;
                        state <= ST_READ;
                    end
                end
                ST_READ: state <= ST_CALC;
                ST_CALC: begin
                    sum_q[cur_ch]  <= sum_next;
                    wptr_q[cur_ch] <= cur_wptr + 1'b1;
                    m_data  <= {in_data[TDATA_WIDTH-1:AUDIO_WIDTH],
                                in_en ? filtered : in_data[AUDIO_WIDTH-1:0]};
                    m_last  <= in_last;
                    m_valid <= 1'b1;
                    state   <= ST_OUT;
                end
                ST_OUT: begin
                    if (m_axis.ready) begin
                        m_valid <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_FLUSH;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_multichannel_boxcar_filter.sv
// Self-checking bench: randomized beats against a queue-based moving-average model.
module tb_axis_multichannel_boxcar_filter;
    localparam int TW = 32;
    localparam int AW = 24;
    localparam int CH = 2;
    localparam int ML = 8;
    localparam int FLUSH_LEN = CH << ML;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       filter_enable;
    logic [3:0] window_log2;
    logic       frame_err, busy_flush;

    axis_multichannel_boxcar_filter_if #(.TDATA_WIDTH(TW)) s_axis ();
    axis_multichannel_boxcar_filter_if #(.TDATA_WIDTH(TW)) m_axis ();

    axis_multichannel_boxcar_filter #(
        .TDATA_WIDTH  (TW),
        .AUDIO_WIDTH  (AW),
        .CHANNELS     (CH),
        .MAX_LOG2_WIN (ML)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .filter_enable (filter_enable),
        .window_log2   (window_log2),
        .s_axis        (s_axis),
        .m_axis        (m_axis),
        .frame_err     (frame_err),
        .busy_flush    (busy_flush)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int mk;            // active log2 window
    int mch;           // expected channel of next beat
    bit merr;          // expected frame_err
    int hist [CH][$];  // last 2^mk samples per channel, oldest first

    function automatic int clampk(input int w);
        return (w > ML) ? ML : w;
    endfunction

    function automatic void mflush();
        for (int c = 0; c < CH; c++) begin
            hist[c].delete();
            for (int i = 0; i < (1 << mk); i++) hist[c].push_back(0);
        end
    endfunction

    function automatic logic [31:0] mstep(input logic [31:0] d, input bit last, input bit en);
        int smp; longint s; longint dd; longint num; longint q; logic [31:0] r;
        smp = int'($signed(d[AW-1:0]));
        hist[mch].push_back(smp);
        void'(hist[mch].pop_front());
        s = 0;
        for (int i = 0; i < hist[mch].size(); i++) s += hist[mch][i];
        dd  = longint'(1) << mk;
        num = s + dd / 2;
        // floor division, i.e. round half toward +inf of s/dd
        q   = (num >= 0) ? num / dd : -((-num + dd - 1) / dd);
        r   = d;
        if (en) r[AW-1:0] = q[AW-1:0];
        if (last && mch != CH - 1) merr = 1'b1;
        mch = (last || mch == CH - 1) ? 0 : mch + 1;
        return r;
    endfunction

    // ---------------- stimulus tasks ----------------
    // Starts at a negedge where busy_flush is already high.
    task automatic count_flush(input bit outs_zero);
        int cnt; int rb;
        cnt = 0; rb = 0;
        while (busy_flush && cnt < 4 * FLUSH_LEN) begin
            if (s_axis.ready || m_axis.valid) rb++;
            if (outs_zero && (m_axis.data !== '0 || m_axis.last || frame_err)) rb++;
            cnt++;
            @(negedge clk);
        end
        chk("flush_len", cnt, FLUSH_LEN);
        chk("flush_outs", rb, 0);
        chk("ready_after_flush", s_axis.ready, 1);
    endtask

    task automatic do_reset(input int w);
        @(negedge clk);
        reset = 1'b1; window_log2 = 4'(w); s_axis.valid = 1'b0; m_axis.ready = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        chk("rst_mvalid", m_axis.valid, 0);
        chk("rst_mdata", m_axis.data, 0);
        chk("rst_mlast", m_axis.last, 0);
        chk("rst_ferr", frame_err, 0);
        chk("rst_busy", busy_flush, 1);
        reset = 1'b0;
        mk = clampk(w); mch = 0; merr = 1'b0; mflush();
        count_flush(1'b1);
    endtask

    task automatic set_win(input int w);
        int n;
        @(negedge clk);
        window_log2 = 4'(w);
        if (clampk(w) != mk) begin
            mk = clampk(w); mflush();
            n = 0;
            while (!busy_flush && n < 10) begin @(negedge clk); n++; end
            chk("flush_start", busy_flush, 1);
            count_flush(1'b0);
        end
    endtask

    task automatic xact(input logic [31:0] d, input bit last, input bit en, input int stall);
        logic [31:0] ed; logic [31:0] hd; int n; int hb;
        @(negedge clk);
        s_axis.data = d; s_axis.last = last; s_axis.valid = 1'b1; filter_enable = en;
        n = 0;
        while (!s_axis.ready && n < 2000) begin @(negedge clk); n++; end
        if (n >= 2000) chk("s_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        // scramble inputs after the handshake; the DUT must have latched them
        s_axis.valid = 1'b0; s_axis.last = 1'b0; s_axis.data = $urandom;
        filter_enable = ~en;
        ed = mstep(d, last, en);
        n = 0;
        do begin @(negedge clk); n++; end while (!m_axis.valid && n < 20);
        chk("latency", n, 3);
        chk("data", m_axis.data, ed);
        chk("last", m_axis.last, last);
        chk("frame_err", frame_err, merr);
        hd = m_axis.data; hb = 0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (m_axis.data !== hd || !m_axis.valid || m_axis.last !== last || s_axis.ready) hb++;
        end
        if (stall > 0) chk("hold", hb, 0);
        m_axis.ready = 1'b1;
        @(posedge clk);
        #1;
        m_axis.ready = 1'b0;
        chk("valid_drop", m_axis.valid, 0);
    endtask

    task automatic frame(input logic [31:0] d0, input logic [31:0] d1, input bit en);
        xact(d0, 1'b0, en, 0);
        xact(d1, 1'b1, en, 0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] rd; bit rl; bit re; int n;
        s_axis.valid = 1'b0; s_axis.data = '0; s_axis.last = 1'b0;
        m_axis.ready = 1'b0; filter_enable = 1'b1; window_log2 = 4'd2;

        do_reset(2);

        // ramp on channel 0, zeros on channel 1: expect 1,3,6,10,14 / 0
        for (int i = 1; i <= 5; i++) frame(32'(4 * i), 32'd0, 1'b1);

        // k=1 rounding of negatives: -5 -> -2, then -5 -> -5
        set_win(1);
        frame(32'h00FF_FFFB, 32'd0, 1'b1);
        frame(32'h00FF_FFFB, 32'd0, 1'b1);

        // bypass then re-enable mid-stream
        frame(32'hAB12_3456, 32'h0000_0007, 1'b0);
        frame($urandom, $urandom, 1'b1);

        // window change 1 -> 3 restarts from zero history
        set_win(3);
        for (int i = 0; i < 3; i++) frame($urandom, $urandom, 1'b1);

        // last on channel 0: sticky frame_err, next beat is channel 0 again
        xact($urandom, 1'b1, 1'b1, 0);
        xact($urandom, 1'b0, 1'b1, 0);
        xact($urandom, 1'b1, 1'b1, 0);

        // downstream stall for 10 cycles
        xact($urandom, 1'b0, 1'b1, 10);
        xact($urandom, 1'b1, 1'b1, 10);

        // request above max is clamped to MAX_LOG2_WIN (read slot == write slot)
        set_win(12);
        for (int i = 0; i < 24; i++) begin
            rd = $urandom; re = 1'($urandom_range(0, 3) != 0);
            rl = (mch == CH - 1);
            if ($urandom_range(0, 9) == 0) rl = ~rl;
            xact(rd, rl, re, $urandom_range(0, 3));
        end

        // identity window with random traffic
        set_win(0);
        for (int i = 0; i < 12; i++) begin
            rd = $urandom; re = 1'($urandom_range(0, 1));
            xact(rd, (mch == CH - 1), re, $urandom_range(0, 2));
        end

        // reset while a sample waits in OUT: output drops on the next edge
        set_win(2);
        @(negedge clk);
        s_axis.data = $urandom; s_axis.last = 1'b0; s_axis.valid = 1'b1;
        n = 0;
        while (!s_axis.ready && n < 2000) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 s_axis.valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_valid", m_axis.valid, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_drop_valid", m_axis.valid, 0);
        chk("rst_clear_ferr", frame_err, 0);
        do_reset(2);
        for (int i = 0; i < 3; i++) frame($urandom, $urandom, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
